// File: rtl/i2c_interface_2.sv
// Single-master I2C poller: one pointer write after reset, then endless single-byte
// reads of one register, each published with a 24-bit timestamp.
module i2c_interface_2 #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter logic [7:0] REG_ADDR    = 8'h00,
  parameter int         IDLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] timestamp,
  output logic        scl,
  output logic [31:0] data,
  output logic [7:0]  state,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    ADDR    = 4'd2,
    RW      = 4'd3,
    ACK_IN  = 4'd4,
    ACK_OUT = 4'd5,
    INIT    = 4'd6,
    DATA    = 4'd7,
    STOP    = 4'd8
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);

  state_t      cur;
  state_t      nxt;
  logic        phase;
  logic [15:0] cnt;
  logic        init_done;
  logic        ptr_sent;   // the ACK_IN being served follows the pointer byte
  logic [7:0]  rx_byte;
  logic        sda_low;

  // State register plus bit/idle counter; phase and count restart on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= IDLE;
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur) begin
        phase <= 1'b0;
        cnt   <= '0;
      end else begin
        phase <= ~phase;
        if (cur == IDLE || phase) cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (cnt == IDLE_LAST) nxt = START;
      START:   if (phase) nxt = ADDR;
      ADDR:    if (phase && cnt == 16'd6) nxt = RW;
      RW:      if (phase) nxt = ACK_IN;
      ACK_IN: begin
        if (phase) begin
          if (sda == 1'b0) begin
            if (ptr_sent)       nxt = STOP;
            else if (init_done) nxt = DATA;
            else                nxt = INIT;
          end else begin
            nxt = STOP;
          end
        end
      end
      INIT:    if (phase && cnt == 16'd7) nxt = ACK_IN;
      DATA:    if (phase && cnt == 16'd7) nxt = ACK_OUT;
      ACK_OUT: if (phase) nxt = STOP;
      STOP:    if (phase) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (cur)
      IDLE:  scl = 1'b1;
      START: sda_low = phase;
      ADDR: begin
        scl     = phase;
        sda_low = ~SLAVE_ADDR[3'd6 - cnt[2:0]];
      end
      RW: begin
        scl     = phase;
        sda_low = ~init_done;
      end
      INIT: begin
        scl     = phase;
        sda_low = ~REG_ADDR[3'd7 - cnt[2:0]];
      end
      STOP: begin
        scl     = phase;
        sda_low = 1'b1;
      end
      default: scl = phase;
    endcase
  end

  // Datapath: sampling happens on the edge that closes phase 1 of a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done <= 1'b0;
      ptr_sent  <= 1'b0;
      rx_byte   <= '0;
      data      <= '0;
    end else begin
      if (cur == ACK_IN && phase) begin
        ptr_sent <= 1'b0;
        if (sda == 1'b0 && ptr_sent) init_done <= 1'b1;
      end
      if (cur == INIT && phase && cnt == 16'd7) ptr_sent <= 1'b1;
      if (cur == DATA && phase) rx_byte <= {rx_byte[6:0], sda};
      if (cur == ACK_OUT && phase) data <= {timestamp, rx_byte};
    end
  end

  assign sda   = sda_low ? 1'b0 : 1'bz;
  assign state = {4'b0000, cur};

endmodule

// File: tb/tb_i2c_interface_2.sv
// Bench for i2c_interface_2: bus-level slave, transaction capture and a
// segment-list model of each transaction derived from the protocol rules.
module tb_i2c_interface_2;

  localparam int         IDLE_CYCLES = 16;
  localparam logic [6:0] SA = 7'h68;
  localparam logic [7:0] RA = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] timestamp = '0;
  logic        scl;
  logic [31:0] data;
  logic [7:0]  state;
  wire         sda;
  logic        slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_interface_2 #(
    .SLAVE_ADDR (SA),
    .REG_ADDR   (RA),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .timestamp(timestamp),
    .scl      (scl),
    .data     (data),
    .state    (state),
    .sda      (sda)
  );

  int total = 0;
  int bad   = 0;

  // observation of the current cycle, updated once per negedge
  logic [7:0] cur_state = 8'hff;
  int         cur_len   = 0;
  logic       cur_scl;
  logic       cur_sda;

  // slave behaviour
  logic       slave_ack  = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  // model state: whether the pointer write has completed since reset
  bit m_init_done = 1'b0;

  // expected and captured transactions: each entry is {state[3:0], cycles[7:0]}
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [15:0] exp_bits;
  int          exp_nbits;
  logic [15:0] got_bits;
  int          got_nbits;
  int          bus_err;
  logic [23:0] ts_exit;
  bit          timed_out;

  task automatic tick();
    @(negedge clk);
    if (state == cur_state) cur_len++;
    else begin
      cur_state = state;
      cur_len   = 1;
    end
    cur_scl   = scl;
    cur_sda   = sda;
    timestamp = 24'($urandom);
    if (rst)                slave_low = 1'b0;
    else if (state == 8'd4) slave_low = slave_ack;
    else if (state == 8'd7) slave_low = ~slave_byte[7 - (cur_len - 1) / 2];
    else                    slave_low = 1'b0;
  endtask

  // Expected segment list and master-driven bits from the protocol rules.
  task automatic model_txn(input bit write, input bit ack);
    exp_q = {};
    exp_q.push_back({4'd1, 8'd2});
    exp_q.push_back({4'd2, 8'd14});
    exp_q.push_back({4'd3, 8'd2});
    exp_q.push_back({4'd4, 8'd2});
    if (!ack) begin
      exp_q.push_back({4'd8, 8'd2});
    end else if (write) begin
      exp_q.push_back({4'd6, 8'd16});
      exp_q.push_back({4'd4, 8'd2});
      exp_q.push_back({4'd8, 8'd2});
    end else begin
      exp_q.push_back({4'd7, 8'd16});
      exp_q.push_back({4'd5, 8'd2});
      exp_q.push_back({4'd8, 8'd2});
    end
    if (write && ack) begin
      exp_bits  = {SA, 1'b0, RA};
      exp_nbits = 16;
    end else begin
      exp_bits  = {8'h00, SA, ~write};
      exp_nbits = 8;
    end
  endtask

  // Record one transaction from START back to IDLE.
  task automatic capture();
    int  n;
    logic exp_scl;
    got_q = {};
    got_bits = '0; got_nbits = 0; bus_err = 0; ts_exit = '0; timed_out = 1'b0;
    n = 0;
    while (cur_state != 8'd1 && n < IDLE_CYCLES + 40) begin tick(); n++; end
    if (cur_state != 8'd1) begin timed_out = 1'b1; return; end
    n = 0;
    while (cur_state != 8'd0 && n < 200) begin
      exp_scl = (cur_state == 8'd1) ? 1'b1 : (((cur_len - 1) % 2) == 1);
      if (cur_scl !== exp_scl) bus_err++;
      if (cur_state == 8'd1 && cur_sda !== (cur_len == 1)) bus_err++;
      if (cur_state == 8'd8 && cur_sda !== 1'b0) bus_err++;
      if (cur_scl && (cur_state == 8'd2 || cur_state == 8'd3 || cur_state == 8'd6)) begin
        got_bits = {got_bits[14:0], cur_sda};
        got_nbits++;
      end
      if (cur_state == 8'd5 && cur_len == 2) ts_exit = timestamp;
      if (cur_len == 1) got_q.push_back({cur_state[3:0], 8'd1});
      else got_q[got_q.size() - 1] = {cur_state[3:0], 8'(cur_len)};
      tick();
      n++;
    end
    if (cur_state != 8'd0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    slave_ack = 1'b0;
    repeat (4) begin
      tick();
      total++;
      if (state !== 8'd0 || scl !== 1'b1 || sda !== 1'b1 || data !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: state=%0d scl=%b sda=%b data=%h, want 0 1 1 0", state, scl, sda, data);
      end
    end
    rst = 1'b0;
    m_init_done = 1'b0;
    n = 0;
    while (state != 8'd1 && n < IDLE_CYCLES + 10) begin tick(); n++; end
    total++;
    if (n != IDLE_CYCLES) begin
      bad++;
      $display("FAIL idle_to_start: %0d cycles, want %0d", n, IDLE_CYCLES);
    end
  endtask

  task automatic test_init_write();
    slave_ack = 1'b1;
    model_txn(!m_init_done, 1'b1);
    capture();
    total++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL init_runs: timeout=%0d segments=%0d, want %0d", timed_out, got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL init_seg%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (got_nbits != exp_nbits || got_bits !== exp_bits) begin
      bad++;
      $display("FAIL init_bits: got %0d bits %h, want %0d bits %h", got_nbits, got_bits, exp_nbits, exp_bits);
    end
    total++;
    if (bus_err != 0 || data !== 32'h0) begin
      bad++;
      $display("FAIL init_bus: bus_err=%0d data=%h, want 0 and 0", bus_err, data);
    end
    m_init_done = 1'b1;
  endtask

  task automatic test_read(input logic [7:0] byte_val, input int reps);
    logic [31:0] exp_data;
    for (int r = 0; r < reps; r++) begin
      slave_ack  = 1'b1;
      slave_byte = (r == 0) ? byte_val : 8'($urandom_range(0, 255));
      model_txn(!m_init_done, 1'b1);
      capture();
      total++;
      if (timed_out || got_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL read_runs: timeout=%0d segments=%0d, want %0d", timed_out, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL read_seg%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
      total++;
      if (got_nbits != exp_nbits || got_bits !== exp_bits || bus_err != 0) begin
        bad++;
        $display("FAIL read_bits: got %0d bits %h err=%0d, want %0d bits %h", got_nbits, got_bits, bus_err, exp_nbits, exp_bits);
      end
      exp_data = {ts_exit, slave_byte};
      total++;
      if (data !== exp_data) begin
        bad++;
        $display("FAIL read_data: got %h want %h", data, exp_data);
      end
    end
  endtask

  task automatic test_nack();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_init_done = 1'b0;
    slave_ack = 1'b0;
    model_txn(!m_init_done, 1'b0);
    capture();
    total++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL nack_runs: timeout=%0d segments=%0d, want %0d", timed_out, got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL nack_seg%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (got_nbits != exp_nbits || got_bits !== exp_bits || bus_err != 0) begin
      bad++;
      $display("FAIL nack_bits: got %0d bits %h err=%0d, want %0d bits %h", got_nbits, got_bits, bus_err, exp_nbits, exp_bits);
    end
    // pointer write was refused, so the next transaction is again a write
    test_init_write();
  endtask

  task automatic test_mid_reset();
    int n;
    test_read(8'h3C, 1);
    slave_byte = 8'hC3;
    n = 0;
    while (!(cur_state == 8'd7 && cur_len == 5) && n < 200) begin tick(); n++; end
    total++;
    if (cur_state != 8'd7) begin
      bad++;
      $display("FAIL midrst_reach_data: state=%0d, want 7", cur_state);
    end
    rst = 1'b1;
    slave_low = 1'b0;
    #1;
    total++;
    if (state !== 8'd0 || scl !== 1'b1 || sda !== 1'b1 || data !== 32'h0) begin
      bad++;
      $display("FAIL midrst_outputs: state=%0d scl=%b sda=%b data=%h, want 0 1 1 0", state, scl, sda, data);
    end
    tick(); tick();
    rst = 1'b0;
    m_init_done = 1'b0;
    test_init_write();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_write();
    test_read(8'h00, 1);
    test_read(8'hA5, 4);
    test_nack();
    test_mid_reset();
    test_read(8'h5A, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_interface_2.md
Name: i2c_interface_2

Overview:
Single-master I2C read engine that periodically polls one register of a fixed slave device. After reset it performs a one-time pointer write (INIT), then repeats single-byte reads forever. Each byte read is published together with a 24-bit timestamp. SCL is generated directly from the system clock. SDA is open-drain: the block drives 0 or releases, and never drives 1.

Parameters:
SLAVE_ADDR, 7'h68, 7-bit slave address sent in ADDR.
REG_ADDR, 8'h00, register pointer byte sent in INIT.
IDLE_CYCLES, 16, clk cycles spent in IDLE before each START (minimum 1).

Ports:
clk  input  1  system clock (nominal 100 kHz); all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
timestamp  input  24  free-running time value, sampled when a read completes.
scl  output  1  I2C clock; driven push-pull.
data  output  32  {timestamp[23:0], rx_byte[7:0]} of the last successful read.
state  output  8  current FSM code, zero-extended from 4 bits.
sda  inout  1  I2C data; the block drives 1'b0 or 1'bz only.

Behaviour:
- State codes: IDLE=0, START=1, ADDR=2, RW=3, ACK_IN=4, ACK_OUT=5, INIT=6, DATA=7, STOP=8.
- Bit timing: each bit slot is 2 clk cycles, tracked by a phase flag.
  - Phase 0: scl=0; the block updates sda.
  - Phase 1: scl=1; sda is sampled on the clk edge that ends phase 1.
- IDLE: scl=1, sda released. Counts IDLE_CYCLES cycles, then goes to START.
- START: 2 cycles with scl=1.
  - Phase 0: sda released.
  - Phase 1: sda=0 (start condition).
- ADDR: 7 bits of SLAVE_ADDR, MSB first (14 cycles).
- RW: 1 bit. Before INIT is done, RW=0 (write). After INIT is done, RW=1 (read).
- ACK_IN: sda released; slave ACK is sampled in phase 1.
  - sda==0 (ACK): continue.
  - Otherwise (NACK): go to STOP. No flags or data are updated.
  - After RW, ACK goes to INIT (write phase) or DATA (read phase).
  - After INIT, ACK goes to STOP and sets the internal init_done flag.
- INIT: shift out REG_ADDR, 8 bits MSB first (16 cycles), then ACK_IN.
- DATA: sda released. 8 bits are sampled MSB first into rx_byte (16 cycles), then ACK_OUT.
- ACK_OUT: master sends NACK (sda released) for 2 cycles. On exit, data <= {timestamp, rx_byte}, then go to STOP.
- STOP: 2 cycles.
  - Phase 0: scl=0, sda=0.
  - Phase 1: scl=1, sda=0.
  - Then IDLE, where sda is released (stop condition).
- Bit and idle counters reset on every state entry.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, scl=1, sda released, data=0, init_done=0, rx_byte=0, counters and phase=0.
  - No STOP is issued on abort.
- Logic value of sda: a bench pull-up is required. Released sda reads 1.

Test Plan:
- Reset check: assert rst for 4 cycles -> state=0, scl=1, sda=z, data=32'h0 while rst=1. START is entered exactly IDLE_CYCLES cycles after rst falls.
- INIT write: slave ACKs by pulling sda low in ACK_IN.
  - Required state sequence: 1, 2 (14 cycles), 3, 4, 6 (16 cycles), 4, 8, 0.
  - scl toggles 0/1 every cycle within slots.
  - Bits seen at scl high are 1101000, 0, then 00000000.
- Read with slave driving 0 in ACK_IN and DATA:
  - After the second IDLE, the RW bit is 1 and the sequence is 1, 2, 3, 4, 7, 5, 8, 0.
  - data becomes {timestamp at ACK_OUT exit, 8'h00}.
- Read pattern: slave drives 8'hA5 in DATA -> data[7:0]=8'hA5 and data[31:8] equals the sampled timestamp. The next loop repeats the read without a new INIT.
- NACK: sda left high in the first ACK_IN -> STOP then IDLE; init_done stays 0. The next transaction is again a write with RW=0.
- Mid-transfer reset: pulse rst during DATA -> immediate IDLE, sda released, data=0, and the INIT sequence is repeated.
